// File: rtl/mem_bridge.sv
// ============================================================================
// Module   : mem_bridge (with mem_bridge_tc timer)
// Purpose  : M-stage data bridge: address decode, byte lanes, load extension,
//            exception codes, two countdown timers and interrupt aggregation.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_bridge_tc (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] c_OFF_CTRL   = 2'd0;
  localparam logic [1:0] c_OFF_PRESET = 2'd1;
  localparam logic [1:0] c_OFF_COUNT  = 2'd2;
  localparam logic [1:0] c_MODE_AUTO  = 2'b01;

  state_t      r_state;
  logic [3:0]  r_ctrl;    // {IM, MODE[1:0], EN}
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;

  // Register writes pre-empt the state machine for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_flag   <= 1'b0;
    end else if (i_we && (i_off == c_OFF_CTRL)) begin
      r_ctrl  <= i_wdata[3:0];
      r_state <= S_IDLE;
      r_flag  <= 1'b0;
    end else if (i_we && (i_off == c_OFF_PRESET)) begin
      r_preset <= i_wdata;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ctrl[0]) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_flag  <= 1'b0;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count <= 32'd0;
            r_flag  <= 1'b1;
            r_state <= S_INT;
          end
        end
        S_INT: begin
          // Auto-reload drops the flag for a one-cycle pulse; other modes
          // disarm the timer and leave the flag latched.
          if (r_ctrl[2:1] == c_MODE_AUTO) r_flag <= 1'b0;
          else                           r_ctrl[0] <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_off)
      c_OFF_CTRL:   o_rdata = {28'd0, r_ctrl};
      c_OFF_PRESET: o_rdata = r_preset;
      c_OFF_COUNT:  o_rdata = r_count;
      default:      o_rdata = 32'd0;
    endcase
  end

  assign o_irq = r_ctrl[3] & r_flag;

endmodule

module mem_bridge #(
  parameter logic [31:0] DM_TOP   = 32'h0000_3000,
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic        m_data_mem_write,
  input  logic [2:0]  m_data_sel,
  input  logic        m_data_req,
  output logic [31:0] m_data_rdata,
  output logic [4:0]  m_data_exc,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ig_addr,
  output logic [3:0]  ig_byteen,
  input  logic        ext_int,
  output logic [5:0]  hw_int
);

  localparam logic [4:0] c_EXC_NONE = 5'd0;
  localparam logic [4:0] c_EXC_ADEL = 5'd4;
  localparam logic [4:0] c_EXC_ADES = 5'd5;

  logic        w_valid, w_word, w_half, w_byte, w_unsigned;
  logic        w_misaligned, w_in_dm, w_in_ig, w_in_tc_any, w_fault, w_wr_ok;
  logic [1:0]  w_in_tc;
  logic [1:0]  w_tc_irq;
  logic [1:0][31:0] w_tc_rdata;
  logic [3:0]  w_be;
  logic [15:0] w_half_lane;
  logic [7:0]  w_byte_lane;
  logic [31:0] w_dm_load;

  assign w_word     = (m_data_sel == 3'd1);
  assign w_half     = (m_data_sel == 3'd2) || (m_data_sel == 3'd3);
  assign w_byte     = (m_data_sel == 3'd4) || (m_data_sel == 3'd5);
  assign w_unsigned = (m_data_sel == 3'd3) || (m_data_sel == 3'd5);
  assign w_valid    = w_word || w_half || w_byte;

  assign w_misaligned = (w_word && (m_data_addr[1:0] != 2'd0)) ||
                        (w_half && m_data_addr[0]);

  assign w_in_dm     = (m_data_addr < DM_TOP);
  assign w_in_ig     = (m_data_addr[31:2] == IG_BASE[31:2]);
  assign w_in_tc_any = |w_in_tc;

  // Timers accept word accesses only, and COUNT is read-only.
  assign w_fault = w_valid && (w_misaligned ||
                               !(w_in_dm || w_in_tc_any || w_in_ig) ||
                               (w_in_tc_any && !w_word) ||
                               (w_in_tc_any && m_data_mem_write &&
                                (m_data_addr[3:2] == 2'd2)));

  assign m_data_exc = w_fault ? (m_data_mem_write ? c_EXC_ADES : c_EXC_ADEL)
                              : c_EXC_NONE;

  assign w_wr_ok = w_valid && m_data_mem_write && !w_fault && !m_data_req;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tc
      // Timer bases are 16-byte aligned; offset 0xC is outside the window.
      localparam logic [31:0] c_BASE = (gi == 0) ? TC0_BASE : TC1_BASE;

      assign w_in_tc[gi] = (m_data_addr[31:4] == c_BASE[31:4]) &&
                           (m_data_addr[3:2] != 2'd3);

      mem_bridge_tc u_tc (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_ok && w_in_tc[gi]),
        .i_off   (m_data_addr[3:2]),
        .i_wdata (m_data_wdata),
        .o_rdata (w_tc_rdata[gi]),
        .o_irq   (w_tc_irq[gi])
      );
    end
  endgenerate

  always_comb begin
    w_be = 4'b0000;
    if (w_word)      w_be = 4'b1111;
    else if (w_half) w_be = m_data_addr[1] ? 4'b1100 : 4'b0011;
    else if (w_byte) w_be = 4'b0001 << m_data_addr[1:0];
  end

  always_comb begin
    dm_wdata = m_data_wdata;
    if (w_half)      dm_wdata = {2{m_data_wdata[15:0]}};
    else if (w_byte) dm_wdata = {4{m_data_wdata[7:0]}};
  end

  assign dm_addr   = {m_data_addr[31:2], 2'b00};
  assign ig_addr   = {m_data_addr[31:2], 2'b00};
  assign dm_byteen = (w_wr_ok && w_in_dm) ? w_be : 4'b0000;
  assign ig_byteen = (w_wr_ok && w_in_ig) ? w_be : 4'b0000;

  assign w_half_lane = m_data_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    w_byte_lane = dm_rdata[7:0];
    case (m_data_addr[1:0])
      2'd0:    w_byte_lane = dm_rdata[7:0];
      2'd1:    w_byte_lane = dm_rdata[15:8];
      2'd2:    w_byte_lane = dm_rdata[23:16];
      default: w_byte_lane = dm_rdata[31:24];
    endcase
  end

  always_comb begin
    w_dm_load = 32'd0;
    if (w_word)
      w_dm_load = dm_rdata;
    else if (w_half)
      w_dm_load = w_unsigned ? {16'd0, w_half_lane}
                             : {{16{w_half_lane[15]}}, w_half_lane};
    else if (w_byte)
      w_dm_load = w_unsigned ? {24'd0, w_byte_lane}
                             : {{24{w_byte_lane[7]}}, w_byte_lane};
  end

  // The interrupt-generator window has no read path and returns zero.
  always_comb begin
    m_data_rdata = 32'd0;
    if (w_valid && !w_fault) begin
      if (w_in_dm)         m_data_rdata = w_dm_load;
      else if (w_in_tc[0]) m_data_rdata = w_tc_rdata[0];
      else if (w_in_tc[1]) m_data_rdata = w_tc_rdata[1];
    end
  end

  assign hw_int = {3'b000, ext_int, w_tc_irq[1], w_tc_irq[0]};

endmodule

`default_nettype wire

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Data-side system bridge directly downstream of the CPU M stage.
- Decodes the CPU data address and steers the access to external DM, two internal timers (TC0, TC1) or an external interrupt-generator window.
- Performs byte-lane generation and load extension, and returns the M-stage exception code.
- Aggregates device interrupts into the 6-bit hardware interrupt vector fed back to CP0.

Parameters:
- DM_TOP, 32'h0000_3000, exclusive upper bound of DM window (DM = [0, DM_TOP)).
- TC0_BASE, 32'h0000_7F00, TC0 base (3 words: CTRL +0, PRESET +4, COUNT +8).
- TC1_BASE, 32'h0000_7F10, TC1 base (same layout).
- IG_BASE, 32'h0000_7F20, interrupt-generator window (1 word).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m_data_addr  in  32  CPU data address
- m_data_wdata  in  32  CPU store data (unshifted, low-aligned)
- m_data_mem_write  in  1  store request
- m_data_sel  in  3  access type: 000 none, 001 word, 010 half signed, 011 half unsigned, 100 byte signed, 101 byte unsigned; 110/111 treated as none
- m_data_req  in  1  M-stage instruction is being squashed
- m_data_rdata  out  32  extended load data to CPU
- m_data_exc  out  5  0 none, 4 AdEL, 5 AdES
- dm_addr  out  32  word-aligned address to DM
- dm_wdata  out  32  lane-shifted store data
- dm_byteen  out  4  DM byte enables
- dm_rdata  in  32  DM read word (combinational)
- ig_addr  out  32  interrupt-generator address
- ig_byteen  out  4  interrupt-generator byte enables
- ext_int  in  1  interrupt-generator request
- hw_int  out  6  {3'b0, ext_int, tc1_irq, tc0_irq}

Behaviour:
Decode and exceptions (combinational; access only when sel is 001–101):
- Alignment: misaligned means word with addr[1:0] != 0, or half with addr[0] != 0.
- Fault conditions: misaligned, or address outside all windows, or timer access with sel != word, or store to COUNT.
- Fault response: m_data_exc = 5 on a store, 4 on a load.
- sel = none: exc = 0 and no side effects regardless of address.
- Write squash: any nonzero exc, or m_data_req = 1, forces dm_byteen, ig_byteen and timer write strobes to 0.

Byte lanes and data:
- Byteen: word 1111; half 0011 << addr[1]*2; byte 0001 << addr[1:0].
- wdata is replicated to the lanes: half {2{h}}, byte {4{b}}.
- Load data: selected lane, sign- or zero-extended per sel.
- Timer reads return the full register; undecoded reads return 0.
- Unused device outputs: dm_addr = {addr[31:2], 2'b00} always; ig_addr likewise. Byteen to a non-selected device is 0.

Timer (one instance per TC):
- Registers: CTRL[3:0] = {IM, MODE[1:0], EN}, reads zero-extended; PRESET[31:0]; COUNT[31:0]; FSM state; irq_flag. tc_irq = CTRL.IM & irq_flag.
- Reset: all registers 0, state IDLE. After reset: all outputs combinationally 0 except hw_int[2] = ext_int.
- A write takes effect at the next clk edge.
- CTRL write: CTRL <= wdata[3:0], state <= IDLE, irq_flag <= 0, FSM step suppressed that cycle.
- PRESET write: PRESET updated, FSM step suppressed that cycle.
- IDLE: EN -> LOAD.
- LOAD: COUNT <= PRESET, irq_flag <= 0 -> CNT.
- CNT: !EN -> IDLE; COUNT > 1 -> COUNT-1; else COUNT <= 0, irq_flag <= 1 -> INT.
- INT, MODE = 00 (one-shot): EN <= 0, flag held -> IDLE.
- INT, MODE = 01 (auto-reload): flag <= 0 (one-cycle pulse) -> IDLE, which reloads.
- MODE 1x behaves as 00.
- Boundary case: PRESET = 0 or 1 reaches INT two cycles after LOAD.

Test Plan:
- sel=001, addr 0x0000_1004, mem_write, wdata 0xDEADBEEF -> dm_byteen 1111, dm_wdata 0xDEADBEEF, exc 0.
- sel=100, addr 0x0000_0007, mem_write, wdata 0x000000A5 -> byteen 1000, wdata 0xA5A5A5A5. Same address as a load with dm_rdata 0x80xxxxxx -> rdata 0xFFFFFF80; with sel=101 -> rdata 0x00000080.
- sel=001, addr 0x0000_0002 load -> exc 4. sel=010, addr 0x7F01 store -> exc 5, byteen 0. Store to 0x7F08 -> exc 5. Load from 0x4000 -> exc 4. sel=000 at 0x4000 -> exc 0.
- Write PRESET 3 then CTRL 0x9 (IM=1, EN=1, mode 00) to TC0 -> COUNT 3,2,1,0; hw_int[0] rises and holds; CTRL reads 0x8. Next CTRL write clears hw_int[0].
- TC1 mode 01 (CTRL 0xB), PRESET 2 -> hw_int[1] pulses high for 1 cycle, periodically. A store with m_data_req=1 to TC1 CTRL leaves the timer unchanged.
- Assert reset mid-count -> next edge: COUNT 0, CTRL 0, hw_int[1:0] 0.
